// File: rtl/piso_param.sv
// Parallel-in/serial-out transmitter with ready/load handshake and a done pulse.
// Optional trailing even-parity bit when PISO_PARAM_PARITY_EN is defined.
module piso_param #(
  parameter int unsigned SIZE      = 16,
  parameter bit          MSB_FIRST = 1'b1
) (
  input  logic            piso_param_cport_clk,
  input  logic            piso_param_cport_rst,
  input  logic            piso_param_cport_en,
  input  logic            piso_param_cport_ld,
  input  logic [SIZE-1:0] piso_param_ipport_pi,
  output logic            piso_param_oport_so,
  output logic            piso_param_oport_rdy,
  output logic            piso_param_oport_busy,
  output logic            piso_param_oport_done
);

  localparam int unsigned   CW   = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [CW-1:0] LAST = CW'(SIZE - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
`ifdef PISO_PARAM_PARITY_EN
    S_PAR   = 2'd2,
`endif
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [SIZE-1:0] shreg_q, shreg_d, shreg_shift;
  logic [CW-1:0]   cnt_q, cnt_d;
`ifdef PISO_PARAM_PARITY_EN
  logic            parity_q, parity_d;
`endif

  always_ff @(posedge piso_param_cport_clk or posedge piso_param_cport_rst) begin
    if (piso_param_cport_rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      cnt_q    <= '0;
`ifdef PISO_PARAM_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      cnt_q    <= cnt_d;
`ifdef PISO_PARAM_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  always_comb begin
    if (MSB_FIRST) shreg_shift = {shreg_q[SIZE-2:0], 1'b0};
    else           shreg_shift = {1'b0, shreg_q[SIZE-1:1]};
  end

  // The counter holds at SIZE-1 on the final shift instead of wrapping.
  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    cnt_d    = cnt_q;
`ifdef PISO_PARAM_PARITY_EN
    parity_d = parity_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (piso_param_cport_ld) begin
          shreg_d  = piso_param_ipport_pi;
          cnt_d    = '0;
          state_d  = S_SHIFT;
`ifdef PISO_PARAM_PARITY_EN
          parity_d = ^piso_param_ipport_pi;
`endif
        end
      end
      S_SHIFT: begin
        if (piso_param_cport_en) begin
          shreg_d = shreg_shift;
          if (cnt_q == LAST) begin
`ifdef PISO_PARAM_PARITY_EN
            state_d = S_PAR;
`else
            state_d = S_DONE;
`endif
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
`ifdef PISO_PARAM_PARITY_EN
      S_PAR: begin
        if (piso_param_cport_en) state_d = S_DONE;
      end
`endif
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    piso_param_oport_so   = 1'b0;
    piso_param_oport_rdy  = 1'b0;
    piso_param_oport_busy = 1'b0;
    piso_param_oport_done = 1'b0;
    case (state_q)
      S_IDLE: piso_param_oport_rdy = 1'b1;
      S_SHIFT: begin
        piso_param_oport_busy = 1'b1;
        piso_param_oport_so   = MSB_FIRST ? shreg_q[SIZE-1] : shreg_q[0];
      end
`ifdef PISO_PARAM_PARITY_EN
      S_PAR: begin
        piso_param_oport_busy = 1'b1;
        piso_param_oport_so   = parity_q;
      end
`endif
      S_DONE:  piso_param_oport_done = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_piso_param.sv
// Bench for piso_param: MSB-first and LSB-first instances driven in lockstep,
// checked against a frame-index reference model.
module tb_piso_param;

  localparam int unsigned SIZE = 16;
`ifdef PISO_PARAM_PARITY_EN
  localparam int FLEN = SIZE + 1;
`else
  localparam int FLEN = SIZE;
`endif

  logic            clk = 1'b0;
  logic            rst, en, ld;
  logic [SIZE-1:0] pi;
  logic            so_m, rdy_m, busy_m, done_m;
  logic            so_l, rdy_l, busy_l, done_l;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  piso_param #(.SIZE(SIZE), .MSB_FIRST(1'b1)) dut_m (
    .piso_param_cport_clk (clk),
    .piso_param_cport_rst (rst),
    .piso_param_cport_en  (en),
    .piso_param_cport_ld  (ld),
    .piso_param_ipport_pi (pi),
    .piso_param_oport_so  (so_m),
    .piso_param_oport_rdy (rdy_m),
    .piso_param_oport_busy(busy_m),
    .piso_param_oport_done(done_m)
  );

  piso_param #(.SIZE(SIZE), .MSB_FIRST(1'b0)) dut_l (
    .piso_param_cport_clk (clk),
    .piso_param_cport_rst (rst),
    .piso_param_cport_en  (en),
    .piso_param_cport_ld  (ld),
    .piso_param_ipport_pi (pi),
    .piso_param_oport_so  (so_l),
    .piso_param_oport_rdy (rdy_l),
    .piso_param_oport_busy(busy_l),
    .piso_param_oport_done(done_l)
  );

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Reference model: the frame is a list of FLEN bits indexed by how many
  // enabled edges have passed since acceptance.
  typedef enum {M_IDLE, M_SEND, M_DONE} mstate_t;
  mstate_t         m_st = M_IDLE;
  logic [SIZE-1:0] m_word = '0;
  int              m_idx = 0;

  function automatic logic frame_bit(input logic [SIZE-1:0] w, input int idx, input bit msb);
    if (idx >= int'(SIZE)) return ^w;
    return msb ? w[int'(SIZE) - 1 - idx] : w[idx];
  endfunction

  task automatic check_outputs();
    logic exp_so_m, exp_so_l;
    logic [2:0] exp_ctl;
    exp_so_m = (m_st == M_SEND) ? frame_bit(m_word, m_idx, 1'b1) : 1'b0;
    exp_so_l = (m_st == M_SEND) ? frame_bit(m_word, m_idx, 1'b0) : 1'b0;
    exp_ctl  = {m_st == M_IDLE, m_st == M_SEND, m_st == M_DONE};
    check("so_msb", 32'(so_m), 32'(exp_so_m));
    check("so_lsb", 32'(so_l), 32'(exp_so_l));
    check("rdy_busy_done_msb", 32'({rdy_m, busy_m, done_m}), 32'(exp_ctl));
    check("rdy_busy_done_lsb", 32'({rdy_l, busy_l, done_l}), 32'(exp_ctl));
  endtask

  task automatic model_edge();
    if (rst) begin
      m_st = M_IDLE;
    end else begin
      case (m_st)
        M_IDLE: if (ld) begin m_word = pi; m_idx = 0; m_st = M_SEND; end
        M_SEND: if (en) begin
          m_idx++;
          if (m_idx == FLEN) m_st = M_DONE;
        end
        default: m_st = M_IDLE;
      endcase
    end
  endtask

  // Called at a falling edge: check, drive, advance one rising edge.
  task automatic tick(input logic l, input logic e, input logic [SIZE-1:0] p);
    check_outputs();
    ld = l;
    en = e;
    pi = p;
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic run_frame(input logic [SIZE-1:0] w, input int stall_at, input int stall_len,
                           input bit junk_ld, input int rst_at, input bit rnd_en);
    int guard, lat, exp_lat, nb, stalls_left;
    bit got_done, aborted;
    logic e, par_m, par_l;
    logic [SIZE-1:0] obs_m, obs_l;
    guard = 0;
    while (!rdy_m && guard < 50) begin
      tick(1'b0, 1'b1, SIZE'($urandom));
      guard++;
    end
    check("rdy_wait", 32'(rdy_m), 32'd1);
    tick(1'b1, 1'b1, w);   // en also high: the load must win
    lat = 0; exp_lat = FLEN; nb = 0; stalls_left = stall_len;
    got_done = 0; aborted = 0; obs_m = '0; obs_l = '0; par_m = 1'b0; par_l = 1'b0;
    while (!got_done && !aborted && lat < 200) begin
      if (done_m) begin
        got_done = 1;
      end else if (rst_at >= 0 && nb == rst_at) begin
        rst = 1'b1;
        #1;
        check("abort_so", 32'(so_m), 32'd0);
        check("abort_rdy", 32'(rdy_m), 32'd1);
        check("abort_busy", 32'(busy_l), 32'd0);
        m_st = M_IDLE;
        tick(1'b0, 1'b1, '0);
        rst = 1'b0;
        aborted = 1;
      end else begin
        e = rnd_en ? ($urandom_range(0, 3) != 0) : 1'b1;
        if (nb == stall_at && stalls_left > 0) begin e = 1'b0; stalls_left--; end
        if (!e) exp_lat++;
        if (e && nb < int'(SIZE)) begin
          obs_m[int'(SIZE) - 1 - nb] = so_m;
          obs_l[nb] = so_l;
        end
        if (e && nb == int'(SIZE)) begin par_m = so_m; par_l = so_l; end
        if (e) nb++;
        tick(junk_ld, e, junk_ld ? '1 : SIZE'($urandom));
        lat++;
      end
    end
    if (aborted) begin
      repeat (SIZE + 2) tick(1'b0, 1'b1, '0);
    end else begin
      check("done_seen", 32'(got_done), 32'd1);
      check("done_latency", 32'(lat), 32'(exp_lat));
      check("bits_msb", 32'(obs_m), 32'(w));
      check("bits_lsb", 32'(obs_l), 32'(w));
`ifdef PISO_PARAM_PARITY_EN
      check("parity_msb", 32'(par_m), 32'(^w));
      check("parity_lsb", 32'(par_l), 32'(^w));
`endif
      tick(1'b0, 1'b0, '0);   // DONE cycle
      tick(1'b0, 1'b0, '0);   // back in IDLE
    end
  endtask

  initial begin
    rst = 1'b1; ld = 1'b0; en = 1'b0; pi = '0;
    @(negedge clk);
    tick(1'b1, 1'b1, SIZE'($urandom));   // ld under reset must be ignored
    tick(1'b0, 1'b1, SIZE'($urandom));
    rst = 1'b0;
    tick(1'b0, 1'b1, '0);
    tick(1'b0, 1'b0, '0);

    run_frame(16'hA5C3, -1, 0, 1'b0, -1, 1'b0);
    run_frame(16'h0001, -1, 0, 1'b0, -1, 1'b0);
    run_frame(16'h8000, -1, 0, 1'b0, -1, 1'b0);
    run_frame(16'hA5C3,  4, 3, 1'b0, -1, 1'b0);
    run_frame(16'hA5C3, -1, 0, 1'b1, -1, 1'b0);
    run_frame(16'hA5C3, -1, 0, 1'b0,  8, 1'b0);
    run_frame(16'hFFFF, SIZE - 1, 2, 1'b0, -1, 1'b0);
    run_frame(16'h0000, -1, 0, 1'b0, -1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      run_frame(SIZE'($urandom), int'($urandom_range(0, SIZE)), int'($urandom_range(0, 3)),
                ($urandom_range(0, 1) != 0), -1, 1'b1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/piso_param.md
Name: piso_param

Overview:
- Parameterised parallel-in/serial-out transmitter: the transmit end of the serial link whose receive end is the dreg_param shift register.
- Accepts one SIZE-bit word through a ready/load handshake.
- Shifts the word out one bit per enabled clock, then pulses done for one cycle.
- Sits between a word-producing datapath and dreg_param's serial input.

Parameters:
SIZE, 16, data word width in bits (minimum 2)
MSB_FIRST, 1, 1 = transmit bit SIZE-1 first; 0 = transmit bit 0 first

Ports:
piso_param_cport_clk  input  1  clock; all state changes on rising edge
piso_param_cport_rst  input  1  reset, asynchronous, active-high
piso_param_cport_en  input  1  shift enable; 0 stalls an in-progress frame
piso_param_cport_ld  input  1  load request; qualifies ipport_pi
piso_param_ipport_pi  input  SIZE  parallel word to transmit
piso_param_oport_so  output  1  serial data out
piso_param_oport_rdy  output  1  1 = word can be accepted this cycle
piso_param_oport_busy  output  1  1 = frame in progress (SHIFT/PAR states)
piso_param_oport_done  output  1  one-cycle pulse after the last bit

Behaviour:
- Reset is asynchronous and active-high on piso_param_cport_rst, with one clock piso_param_cport_clk.
- Reset state is IDLE: shift register = 0, bit counter = 0, so = 0, rdy = 1, busy = 0, done = 0.
- Reset asserted mid-frame aborts the frame immediately. No done pulse is issued for it.
- States:
  - IDLE: rdy = 1, so = 0. On an edge with ld = 1, capture pi into the shift register, clear the counter, go to SHIFT. en is ignored in IDLE.
  - SHIFT: rdy = 0, busy = 1, so = shreg[SIZE-1] if MSB_FIRST, else shreg[0]. so is combinational from the register.
    - On an edge with en = 1: shift one place toward the output end, zero-fill, counter += 1.
    - When the counter equals SIZE-1 and en = 1: go to DONE (or PAR, see Optional Feature).
    - On an edge with en = 0: register, counter and so all hold.
  - DONE: done = 1, so = 0, rdy = 0, busy = 0. Unconditionally returns to IDLE on the next edge.
- Latency: the first bit appears the cycle after the accepting edge. With en held at 1, each bit is valid for exactly one cycle. done asserts SIZE cycles after the accepting edge. The next word can be accepted 2 cycles after the final data bit.
- ld while rdy = 0 is ignored: no capture and no queueing. The producer must hold ld until it sees rdy = 1.
- ld and en asserted together in IDLE: the load wins. No shift occurs on the accepting edge.
- Counter width is $clog2(SIZE). It never wraps inside a frame; it is cleared on load.
- pi is sampled only on the accepting edge. Changes to pi afterwards have no effect on the frame.

Optional Feature:
- Macro: PISO_PARAM_PARITY_EN.
- When defined:
  - An extra state PAR follows the last data bit (entered under the same en condition as DONE).
  - In PAR, so = even parity (XOR) of the captured word and busy = 1.
  - PAR advances to DONE on an edge with en = 1 and holds while en = 0.
  - Frame length becomes SIZE+1 bits; done asserts SIZE+1 cycles after acceptance.
  - The parity bit is computed at capture and stored in a 1-bit register.
- When not defined: no PAR state and no parity register. The frame is exactly SIZE bits.

Test Plan:
1. Reset, then check IDLE outputs -> while rst = 1 and for one cycle after: so = 0, rdy = 1, busy = 0, done = 0.
2. SIZE=16, MSB_FIRST=1, en=1, ld pulse with pi=16'hA5C3 -> so sequence 1,0,1,0,0,1,0,1,1,1,0,0,0,0,1,1 on consecutive cycles. busy high for 16 cycles, then done = 1 for one cycle, then rdy = 1.
3. MSB_FIRST=0, pi=16'h0001 -> so = 1 on the first bit cycle, then 15 zeros. done on cycle 17 after acceptance.
4. Drop en for 3 cycles after bit 4 of 16'hA5C3 -> so holds 0 (bit 4) for 4 cycles total. Remaining bits are unchanged. done arrives 3 cycles late.
5. Assert ld with pi=16'hFFFF during SHIFT of 16'hA5C3 -> ignored. The original frame completes intact. Assert rst at bit 8 -> so = 0 and rdy = 1 immediately, no done pulse.
6. With PISO_PARAM_PARITY_EN defined, send 16'hA5C3 and 16'h0001 -> 17th bit is 0 and 1 respectively. done on cycle 18 after acceptance.
